// File: rtl/perceptron_sequencer_if.sv
// ----------------------------------------------------------------------------
// perceptron_sequencer_if
// Sample/result handshake bundle between a sample producer (master) and the
// perceptron sequencer (slave).
//   in_valid/in_ready    : sample handshake; in_x, in_train, in_target ride it
//   out_valid/out_ready  : result handshake; out_predict, out_sum, out_updated
// ----------------------------------------------------------------------------
interface perceptron_sequencer_if #(
   parameter int SUM_W = 21
);
   logic                    in_valid;
   logic                    in_ready;
   logic [15:0]             in_x;
   logic                    in_train;
   logic                    in_target;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_predict;
   logic signed [SUM_W-1:0] out_sum;
   logic                    out_updated;

   modport master (
      output in_valid, in_x, in_train, in_target, out_ready,
      input  in_ready, out_valid, out_predict, out_sum, out_updated
   );

   modport slave (
      input  in_valid, in_x, in_train, in_target, out_ready,
      output in_ready, out_valid, out_predict, out_sum, out_updated
   );
endinterface

// File: rtl/perceptron_sequencer.sv
// ----------------------------------------------------------------------------
// perceptron_sequencer
// Sequencing and training controller for a 16-input perceptron. Holds the
// bias plus 16 weights, evaluates each sample serially with one adder
// (17 cycles), optionally applies the perceptron learning rule (17 cycles),
// then presents the result until it is consumed.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en/addr/data : weight write port (IDLE only); addr 0 = bias, 1..16 = w
//   bus (slave)     : sample and result valid/ready handshakes
//   weights         : packed register file, bias in [15:0]
//   busy            : controller is not idle
//   err_count       : training mismatches, saturating; clr_stats clears it
// ----------------------------------------------------------------------------
module perceptron_sequencer #(
   parameter int LR    = 1,
   parameter int SUM_W = 21
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [4:0]             wr_addr,
   input  logic [15:0]            wr_data,
   perceptron_sequencer_if.slave  bus,
   output logic [271:0]           weights,
   output logic                   busy,
   output logic [15:0]            err_count,
   input  logic                   clr_stats
);
   typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, RESP} state_t;

   localparam logic [4:0]         LAST_IDX = 5'd16;
   localparam logic signed [16:0] LR_POS   = 17'(LR);
   localparam logic signed [16:0] LR_NEG   = -LR_POS;

   state_t                  state, state_next;
   logic signed [15:0]      rf [0:16];     // rf[0] = bias, rf[k+1] = w[k]
   logic [4:0]              idx;
   logic signed [SUM_W-1:0] acc;
   logic [16:0]             x_q;           // {x, 1}: bit 0 lets the bias join every pass
   logic                    train_q;
   logic                    target_q;
   logic signed [SUM_W-1:0] sum_q;
   logic                    predict_q;
   logic                    updated_q;

   logic                    accept;
   logic                    last;
   logic signed [SUM_W-1:0] term;
   logic signed [SUM_W-1:0] acc_next;
   logic                    predict_next;
   logic                    mismatch;
   logic signed [16:0]      upd_raw;
   logic signed [15:0]      upd_sat;

   // Shared datapath: one accumulate term and one saturating weight update,
   // both selected by idx.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      term         = '0;
      if (x_q[idx]) term = {{(SUM_W-16){rf[idx][15]}}, rf[idx]};
      acc_next     = acc + term;
      predict_next = (acc_next > 0);
      mismatch     = train_q && (predict_next != target_q);
      last         = (idx == LAST_IDX);

      // 17-bit headroom holds any 16-bit weight plus or minus LR.
      upd_raw = 17'({rf[idx][15], rf[idx]}) + (target_q ? LR_POS : LR_NEG);
      upd_sat = upd_raw[15:0];
      if (upd_raw > 17'sh07FFF)       upd_sat = 16'sh7FFF;
      else if (upd_raw < -17'sh08000) upd_sat = 16'sh8000;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            // A weight write owns the cycle; samples wait.
            bus.in_ready = !wr_en && !rst;
            accept       = bus.in_valid && !wr_en && !rst;
            if (accept) state_next = ACCUM;
         end
         ACCUM: begin
            if (last) state_next = mismatch ? UPDATE : RESP;
         end
         UPDATE: begin
            if (last) state_next = RESP;
         end
         RESP: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the register file is flops, not a RAM, and must come out of reset
   // at zero, so it is cleared in the reset branch like any other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 17; i++) rf[i] <= '0;
         idx       <= '0;
         acc       <= '0;
         x_q       <= '0;
         train_q   <= 1'b0;
         target_q  <= 1'b0;
         sum_q     <= '0;
         predict_q <= 1'b0;
         updated_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en && (wr_addr <= LAST_IDX)) rf[wr_addr] <= wr_data;
               if (accept) begin
                  x_q      <= {bus.in_x, 1'b1};
                  train_q  <= bus.in_train;
                  target_q <= bus.in_target;
                  idx      <= '0;
                  acc      <= '0;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= last ? 5'd0 : idx + 5'd1;
               if (last) begin
                  sum_q     <= acc_next;
                  predict_q <= predict_next;
                  updated_q <= mismatch;
               end
            end
            UPDATE: begin
               if (x_q[idx]) rf[idx] <= upd_sat;
               idx <= last ? 5'd0 : idx + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // Counted on the last update cycle; a same-cycle clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           err_count <= '0;
      else if (clr_stats)                                err_count <= '0;
      else if (state == UPDATE && last && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
   end

   for (genvar i = 0; i < 17; i++) begin : g_weights
      assign weights[16*i +: 16] = rf[i];
   end

   assign busy            = (state != IDLE);
   assign bus.out_sum     = sum_q;
   assign bus.out_predict = predict_q;
   assign bus.out_updated = updated_q;
endmodule

// File: tb/tb_perceptron_sequencer.sv
// ----------------------------------------------------------------------------
// tb_perceptron_sequencer
// Self-checking bench: a directed vector table, hand-written corner cases
// (write priority, backpressure, clear priority, saturation, mid-run reset,
// LR=4 instance) and randomized samples scored against a plain-arithmetic
// model of the perceptron rule.
// ----------------------------------------------------------------------------
module tb_perceptron_sequencer;
   localparam int SUM_W   = 21;
   localparam int LR_MAIN = 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_en, clr_stats;
   logic [4:0]   wr_addr;
   logic [15:0]  wr_data;
   logic [271:0] weights;
   logic         busy;
   logic [15:0]  err_count;

   logic         wr4_en, clr4;
   logic [4:0]   wr4_addr;
   logic [15:0]  wr4_data;
   logic [271:0] weights4;
   logic         busy4;
   logic [15:0]  err4;

   perceptron_sequencer_if #(.SUM_W(SUM_W)) bus ();
   perceptron_sequencer_if #(.SUM_W(SUM_W)) bus4 ();

   perceptron_sequencer #(.LR(LR_MAIN), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .bus(bus), .weights(weights), .busy(busy), .err_count(err_count),
      .clr_stats(clr_stats)
   );

   perceptron_sequencer #(.LR(4), .SUM_W(SUM_W)) dut4 (
      .clk(clk), .rst(rst), .wr_en(wr4_en), .wr_addr(wr4_addr), .wr_data(wr4_data),
      .bus(bus4), .weights(weights4), .busy(busy4), .err_count(err4),
      .clr_stats(clr4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   int mw [17];   // mw[0] = bias, mw[k+1] = w[k]
   int m_err;

   function automatic int clamp16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int m_sum(input logic [15:0] x);
      int s = mw[0];
      for (int k = 0; k < 16; k++) if (x[k]) s += mw[k+1];
      return s;
   endfunction

   function automatic logic [271:0] m_bus();
      logic [271:0] v;
      for (int i = 0; i < 17; i++) v[16*i +: 16] = 16'(mw[i]);
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 17; i++) mw[i] = 0;
      m_err = 0;
   endtask

   task automatic m_apply(input logic [15:0] x, input bit train, input bit target,
                          output int e_sum, output bit e_pred, output bit e_upd);
      int d;
      e_sum  = m_sum(x);
      e_pred = (e_sum > 0);
      e_upd  = train && (e_pred != target);
      if (e_upd) begin
         d = target ? LR_MAIN : -LR_MAIN;
         mw[0] = clamp16(mw[0] + d);
         for (int k = 0; k < 16; k++) if (x[k]) mw[k+1] = clamp16(mw[k+1] + d);
         if (m_err < 65535) m_err++;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_bus(input string name, input logic [271:0] act,
                            input logic [271:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic wr(input int addr, input int data);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = addr[4:0];
      wr_data = data[15:0];
      @(negedge clk);
      wr_en = 1'b0;
      if (addr <= 16) mw[addr] = int'($signed(data[15:0]));
   endtask

   // Sends one sample and collects its result. lat is the cycle offset from
   // the accept cycle to the first out_valid cycle (-1 when reset aborted it).
   // While busy the task raises stray in_valid requests; optional knobs pulse
   // clr_stats, drive weight writes, or assert reset at a given offset.
   task automatic send(input logic [15:0] x, input bit train, input bit target,
                       input int hold, input int clr_at, input int wr_at, input int rst_at,
                       output int lat, output int o_sum, output bit o_pred, output bit o_upd);
      int guard;
      @(negedge clk);
      bus.in_x      = x;
      bus.in_train  = train;
      bus.in_target = target;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk); #1; guard++;
      end
      if (guard >= 50) check("accept_timeout", bus.in_ready, 1);
      @(negedge clk);
      lat = 1;
      while (!bus.out_valid && lat < 60) begin
         bus.in_valid  = (lat >= 2 && lat <= 10);
         bus.in_x      = 16'($urandom);
         bus.in_train  = 1'b1;
         bus.in_target = 1'($urandom);
         clr_stats     = (clr_at > 0) && (lat == clr_at);
         wr_en         = (wr_at > 0) && (lat >= wr_at) && (lat < wr_at + 3);
         wr_addr       = 5'd0;
         wr_data       = 16'h1234;
         #1;
         if (lat == 5) check("in_ready_busy", bus.in_ready, 0);
         if (lat == rst_at) begin
            rst = 1'b1;
            #1;
            check_bus("rst_weights", weights, '0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_out_sum", $signed(bus.out_sum), 0);
            check("rst_flags", {bus.out_predict, bus.out_updated}, 0);
            check("rst_err", err_count, 0);
            check("rst_in_ready", bus.in_ready, 0);
            bus.in_valid = 1'b0;
            wr_en        = 1'b0;
            clr_stats    = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            #1;
            check("post_rst_in_ready", bus.in_ready, 1);
            check("post_rst_out_valid", bus.out_valid, 0);
            lat = -1; o_sum = 0; o_pred = 1'b0; o_upd = 1'b0;
            return;
         end
         @(negedge clk);
         lat++;
      end
      bus.in_valid = 1'b0;
      clr_stats    = 1'b0;
      wr_en        = 1'b0;
      o_sum  = int'($signed(bus.out_sum));
      o_pred = bus.out_predict;
      o_upd  = bus.out_updated;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_sum", $signed(bus.out_sum), o_sum);
         check("hold_flags", {bus.out_predict, bus.out_updated}, {o_pred, o_upd});
         check("hold_valid", bus.out_valid, 1);
         check("hold_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      check("release_valid", bus.out_valid, 0);
      check("release_in_ready", bus.in_ready, 1);
   endtask

   task automatic run_model(input string tag, input logic [15:0] x, input bit train,
                            input bit target, input int hold, input int clr_at, input int wr_at);
      int e_sum, lat, o_sum;
      bit e_pred, e_upd, o_pred, o_upd;
      m_apply(x, train, target, e_sum, e_pred, e_upd);
      if (clr_at > 0) m_err = 0;   // clear in the increment cycle wins
      send(x, train, target, hold, clr_at, wr_at, 0, lat, o_sum, o_pred, o_upd);
      check({tag, "_latency"}, lat, e_upd ? 35 : 18);
      check({tag, "_sum"}, o_sum, e_sum);
      check({tag, "_predict"}, o_pred, e_pred);
      check({tag, "_updated"}, o_upd, e_upd);
      check({tag, "_err"}, err_count, m_err);
      check_bus({tag, "_weights"}, weights, m_bus());
   endtask

   task automatic rst_abort(input int rst_at);
      int lat, o_sum;
      bit o_pred, o_upd;
      logic [15:0] x;
      x = 16'($urandom);
      // Target chosen against the model so the sample always trains.
      send(x, 1'b1, !(m_sum(x) > 0), 0, 0, 0, rst_at, lat, o_sum, o_pred, o_upd);
      check("rst_abort_lat", lat, -1);
      m_reset();
   endtask

   task automatic wr4(input int addr, input int data);
      @(negedge clk);
      wr4_en   = 1'b1;
      wr4_addr = addr[4:0];
      wr4_data = data[15:0];
      @(negedge clk);
      wr4_en = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [15:0] x;
      bit          train;
      bit          target;
      int          sum;
      bit          pred;
      bit          upd;
      int          lat;
      int          err;
   } vec_t;

   vec_t tbl [7];
   int   t_sum, t_lat, o_sum;
   bit   t_pred, t_upd, o_pred, o_upd;
   int   guard;

   initial begin
      tbl[0] = '{16'hFFFF, 1'b0, 1'b0,  0, 1'b0, 1'b0, 18, 0};
      tbl[1] = '{16'h0003, 1'b1, 1'b1,  0, 1'b0, 1'b1, 35, 1};
      tbl[2] = '{16'h0003, 1'b1, 1'b1,  3, 1'b1, 1'b0, 18, 1};
      tbl[3] = '{16'h0000, 1'b1, 1'b0,  1, 1'b1, 1'b1, 35, 2};
      tbl[4] = '{16'h0002, 1'b0, 1'b0,  1, 1'b1, 1'b0, 18, 2};
      tbl[5] = '{16'hFFFF, 1'b1, 1'b0,  2, 1'b1, 1'b1, 35, 3};
      tbl[6] = '{16'h0004, 1'b0, 1'b0, -2, 1'b0, 1'b0, 18, 3};

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_stats = 1'b0;
      bus.in_valid = 1'b0; bus.in_x = '0; bus.in_train = 1'b0; bus.in_target = 1'b0;
      bus.out_ready = 1'b0;
      wr4_en = 1'b0; wr4_addr = '0; wr4_data = '0; clr4 = 1'b0;
      bus4.in_valid = 1'b0; bus4.in_x = '0; bus4.in_train = 1'b0; bus4.in_target = 1'b0;
      bus4.out_ready = 1'b0;
      m_reset();

      repeat (3) @(negedge clk);
      #1;
      check("reset_in_ready", bus.in_ready, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check_bus("reset_weights", weights, '0);
      check("reset_err", err_count, 0);
      check("reset_out_sum", $signed(bus.out_sum), 0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", bus.in_ready, 1);
      check("idle_busy", busy, 0);

      // Directed training sequence from all-zero weights.
      for (int i = 0; i < 7; i++) begin
         m_apply(tbl[i].x, tbl[i].train, tbl[i].target, t_sum, t_pred, t_upd);
         send(tbl[i].x, tbl[i].train, tbl[i].target, 0, 0, 0, 0, t_lat, o_sum, o_pred, o_upd);
         check($sformatf("vec%0d_latency", i), t_lat, tbl[i].lat);
         check($sformatf("vec%0d_sum", i), o_sum, tbl[i].sum);
         check($sformatf("vec%0d_predict", i), o_pred, tbl[i].pred);
         check($sformatf("vec%0d_updated", i), o_upd, tbl[i].upd);
         check($sformatf("vec%0d_err", i), err_count, tbl[i].err);
         check_bus($sformatf("vec%0d_weights", i), weights, m_bus());
      end

      // clr_stats in IDLE, then a clear that collides with the increment.
      @(negedge clk); clr_stats = 1'b1;
      @(negedge clk); clr_stats = 1'b0; #1;
      m_err = 0;
      check("clr_idle_err", err_count, 0);
      run_model("clr_collide", 16'h0000, 1'b1, 1'b1, 0, 34, 0);

      // Weight writes and a plain inference.
      wr(0, 5);
      wr(1, 3);
      #1;
      check("wr_bias", weights[15:0], 16'd5);
      check("wr_w0", weights[31:16], 16'd3);
      run_model("wr_infer", 16'h0001, 1'b0, 1'b0, 0, 0, 0);
      check("wr_infer_sum8", $signed(bus.out_sum), 8);

      // Saturation at both ends of one update.
      wr(0, -32768);
      wr(1, 32767);
      run_model("sat", 16'h0001, 1'b1, 1'b1, 0, 0, 0);
      check("sat_bias", weights[15:0], 16'h8001);
      check("sat_w0", weights[31:16], 16'h7FFF);

      // Write beats a same-cycle sample; out-of-range address is ignored.
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h0007;
      bus.in_valid = 1'b1; bus.in_x = 16'hFFFF;
      #1;
      check("prio_in_ready", bus.in_ready, 0);
      @(negedge clk);
      wr_en = 1'b0; bus.in_valid = 1'b0;
      #1;
      mw[3] = 7;
      check("prio_write", weights[63:48], 16'h0007);
      check("prio_not_busy", busy, 0);
      wr(20, 16'h5555);
      #1;
      check_bus("wr_addr_ignored", weights, m_bus());

      run_model("backpressure", 16'($urandom), 1'b0, 1'b0, 10, 0, 0);
      run_model("wr_in_accum", 16'h00FF, 1'b0, 1'b0, 0, 0, 3);

      // Reset during UPDATE, then during ACCUM, then normal operation.
      rst_abort(25);
      wr(0, 100);
      wr(5, -7);
      rst_abort(9);
      run_model("after_rst", 16'hFFFF, 1'b1, 1'b1, 0, 0, 0);

      // LR = 4 instance: bias and w1 move by 4, w0 clamps at -32768.
      wr4(0, 32767);
      wr4(1, -32767);
      wr4(2, 1);
      @(negedge clk);
      bus4.in_x = 16'h0003; bus4.in_train = 1'b1; bus4.in_target = 1'b0; bus4.in_valid = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      guard = 0;
      while (!bus4.out_valid && guard < 60) begin
         @(negedge clk); guard++;
      end
      check("lr4_latency", guard, 34);
      check("lr4_sum", $signed(bus4.out_sum), 1);
      check("lr4_updated", bus4.out_updated, 1);
      check("lr4_bias", weights4[15:0], 16'h7FFB);
      check("lr4_w0", weights4[31:16], 16'h8000);
      check("lr4_w1", weights4[47:32], 16'hFFFD);
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus4.out_ready = 1'b0;

      // Randomized samples with occasional random writes.
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 31), $urandom_range(0, 65535));
         run_model($sformatf("rnd%0d", n), 16'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
